vga_sprite_pipe: RTL



---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_sync_delay.sv | 24 ++
 rtl/vga_sprite_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour type and default palette values.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = 525;

    localparam logic [11:0] BG_COLOR          = 12'h9CF;
    localparam logic [11:0] TRANSPARENT_COLOR = 12'hF0F;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;
endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH x WIDTH shift register with async active-high clear to RST_VAL.
module vga_sync_delay #(
    parameter int               DEPTH   = 3,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= {DEPTH{RST_VAL}};
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_sprite_pipe.sv
// Pixel stage behind the VGA timer: one ROM-backed sprite over a flat
// background, 3-cycle latency with syncs kept aligned to colour.
module vga_sprite_pipe #(
    parameter int          SPRITE_W          = 32,
    parameter int          SPRITE_H          = 32,
    parameter int          V_VISIBLE         = vga_pkg::V_VISIBLE,
    parameter logic [11:0] BG_COLOR          = vga_pkg::BG_COLOR,
    parameter logic [11:0] TRANSPARENT_COLOR = vga_pkg::TRANSPARENT_COLOR,
    parameter int          ROM_AW            = $clog2(SPRITE_W*SPRITE_H)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              visible_i,
    input  logic [9:0]        position_x_i,
    input  logic [9:0]        position_y_i,
    input  logic [9:0]        sprite_x_i,
    input  logic [9:0]        sprite_y_i,
    input  logic              sprite_en_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [11:0]       rom_data_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [11:0]       rgb_o,
    output logic              frame_done_o
);
    import vga_pkg::*;

    localparam int XB = $clog2(SPRITE_W);
    localparam int YB = ROM_AW - XB;

    logic [9:0]        shadow_x_q, shadow_y_q;
    logic              shadow_en_q;
    logic              frame_done_q;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    rgb_t              rgb_q, rgb_d;

    logic        latch;
    logic [10:0] px, py, sx, sy;
    logic        in_box_d;
    logic [XB-1:0] dx;
    logic [YB-1:0] dy;
    logic [1:0]  sync_s3;
    logic        vis_s2, in_box_s2;

    assign latch = (position_y_i == 10'(V_VISIBLE)) && (position_x_i == '0);

    // 11-bit compare so a sprite near the right/bottom edge clips instead of wrapping
    assign px = {1'b0, position_x_i};
    assign py = {1'b0, position_y_i};
    assign sx = {1'b0, shadow_x_q};
    assign sy = {1'b0, shadow_y_q};
    assign in_box_d = shadow_en_q
                   && (px >= sx) && (px < sx + 11'(SPRITE_W))
                   && (py >= sy) && (py < sy + 11'(SPRITE_H));

    // Only the low bits of the offsets matter for the row-major address
    assign dx = position_x_i[XB-1:0] - shadow_x_q[XB-1:0];
    assign dy = position_y_i[YB-1:0] - shadow_y_q[YB-1:0];

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (in_box_d) rom_addr_d = {dy, dx};
    end

    always_comb begin
        rgb_d = BG_COLOR;
        if (!vis_s2)
            rgb_d = '0;
        else if (in_box_s2 && rom_data_i != TRANSPARENT_COLOR)
            rgb_d = rom_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_x_q   <= '0;
            shadow_y_q   <= '0;
            shadow_en_q  <= 1'b0;
            frame_done_q <= 1'b0;
            rom_addr_q   <= '0;
            rgb_q        <= '0;
        end else begin
            frame_done_q <= latch;
            if (latch) begin
                shadow_x_q  <= sprite_x_i;
                shadow_y_q  <= sprite_y_i;
                shadow_en_q <= sprite_en_i;
            end
            rom_addr_q <= rom_addr_d;
            rgb_q      <= rgb_d;
        end
    end

    vga_sync_delay #(.DEPTH(3), .WIDTH(2), .RST_VAL(2'b11)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({hsync_i, vsync_i}),
        .q_o   (sync_s3)
    );

    // visible/in_box only need to reach S2, where the colour mux consumes them
    vga_sync_delay #(.DEPTH(2), .WIDTH(2), .RST_VAL(2'b00)) u_vis (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({visible_i, in_box_d}),
        .q_o   ({vis_s2, in_box_s2})
    );

    assign hsync_o      = sync_s3[1];
    assign vsync_o      = sync_s3[0];
    assign rgb_o        = rgb_q;
    assign rom_addr_o   = rom_addr_q;
    assign frame_done_o = frame_done_q;
endmodule
